// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared types, widths and helpers for the instruction fetch controller.
// Optional feature macro: IF_FETCH_STAT_EN (adds the fetch_cnt push counter).
package inst_fetch_ctrl_pkg;

    localparam int unsigned INST_ADDR_W   = 32;
    localparam int unsigned INST_W        = 32;
    localparam int unsigned STAT_W        = 32;
    localparam int unsigned DEF_DEPTH     = 4;
    localparam int unsigned DEF_MEM_WORDS = 26;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_RUN  = 2'd1,
        IF_HALT = 2'd2
    } if_state_e;

    // One fetch-queue entry: the word and the PC it was fetched from.
    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
    } fq_entry_t;

    // Saturating increment for statistics counters.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Cache, redirect and decode-side signals of the fetch controller.
// Optional feature macro: IF_FETCH_STAT_EN (adds fetch_cnt).
interface inst_fetch_ctrl_if;
    import inst_fetch_ctrl_pkg::*;

    logic                   start;
    logic                   cache_ce;
    logic [INST_ADDR_W-1:0] cache_addr;
    logic [INST_W-1:0]      cache_inst;
    logic                   cache_enable;
    logic                   jump_en;
    logic [INST_ADDR_W-1:0] jump_addr;
    logic                   inst_valid;
    logic [INST_W-1:0]      inst;
    logic [INST_ADDR_W-1:0] inst_pc;
    logic                   inst_ready;
    logic                   halted;
`ifdef IF_FETCH_STAT_EN
    logic [STAT_W-1:0]      fetch_cnt;
`endif

    // Fetch controller side.
    modport master (
        input  start, cache_inst, cache_enable, jump_en, jump_addr, inst_ready,
`ifdef IF_FETCH_STAT_EN
        output fetch_cnt,
`endif
        output cache_ce, cache_addr, inst_valid, inst, inst_pc, halted
    );

    // Cache / decode / branch-unit side.
    modport slave (
        output start, cache_inst, cache_enable, jump_en, jump_addr, inst_ready,
`ifdef IF_FETCH_STAT_EN
        input  fetch_cnt,
`endif
        input  cache_ce, cache_addr, inst_valid, inst, inst_pc, halted
    );

endinterface

// File: rtl/inst_fetch_ctrl_fetch_queue.sv
// DEPTH-entry FIFO of {pc, inst} pairs with push, pop and synchronous flush.
module inst_fetch_ctrl_fetch_queue
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push_i,
    input  logic      pop_i,
    input  logic      flush_i,
    input  fq_entry_t wdata_i,
    output fq_entry_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fq_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    // Occupancy flags and qualified push/pop; flush wins over both.
    always_comb begin
        full_o  = (count_q == CNT_W'(DEPTH));
        empty_o = (count_q == CNT_W'(0));
        do_push = push_i && !flush_i && (!full_o || pop_i);
        do_pop  = pop_i && !flush_i && !empty_o;
        head_o  = mem_q[rd_ptr_q];
    end

    // Pointer, count and storage update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, drives the combinational cache,
// buffers fetched words in a small queue and hands them to decode.
// Optional feature macro: IF_FETCH_STAT_EN (saturating fetch_cnt of pushes).
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned MEM_WORDS = DEF_MEM_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    inst_fetch_ctrl_if.master fif
);

    localparam logic [INST_ADDR_W-1:0] PC_LIMIT = INST_ADDR_W'(MEM_WORDS * 4);
    localparam logic [INST_ADDR_W-1:0] PC_STEP  = INST_ADDR_W'(4);
    localparam logic [INST_ADDR_W-1:0] PC_MASK  = ~INST_ADDR_W'(3);

    if_state_e              state_q, state_d;
    logic [INST_ADDR_W-1:0] pc_q, pc_d;
    logic                   jump_act;
    logic                   inst_valid_c;
    logic                   cache_ce_c;
    logic                   push, pop;
    logic                   fq_full, fq_empty;
    fq_entry_t              fq_head, fq_wdata;

    // Handshake glue: jump masks both sides, a full queue fetches only alongside a pop.
    always_comb begin
        jump_act     = fif.jump_en && (state_q != IF_IDLE);
        inst_valid_c = !fq_empty && !fif.jump_en;
        pop          = inst_valid_c && fif.inst_ready;
        cache_ce_c   = (state_q == IF_RUN) && !fif.jump_en && (pc_q < PC_LIMIT)
                       && (!fq_full || pop);
        push         = cache_ce_c && fif.cache_enable;
        fq_wdata     = '{pc: pc_q, inst: fif.cache_inst};
    end

    // Next state and next PC; a redirect overrides everything outside IDLE.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (jump_act) begin
            state_d = IF_RUN;
            pc_d    = fif.jump_addr & PC_MASK;
        end else begin
            case (state_q)
                IF_IDLE: begin
                    if (fif.start) begin
                        state_d = IF_RUN;
                        pc_d    = '0;
                    end
                end
                IF_RUN: begin
                    if (push) begin
                        pc_d = pc_q + PC_STEP;
                    end else if (pc_q >= PC_LIMIT) begin
                        state_d = IF_HALT;
                    end
                end
                IF_HALT: begin
                    state_d = IF_HALT;
                end
                default: begin
                    state_d = IF_IDLE;
                end
            endcase
        end
    end

    // FSM state and PC registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IF_IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    inst_fetch_ctrl_fetch_queue #(
        .DEPTH (DEPTH)
    ) u_fetch_queue (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (fif.jump_en),
        .wdata_i (fq_wdata),
        .head_o  (fq_head),
        .full_o  (fq_full),
        .empty_o (fq_empty)
    );

    // Cache and decode drive; data buses read zero when not qualified.
    always_comb begin
        fif.cache_ce   = cache_ce_c;
        fif.cache_addr = cache_ce_c ? pc_q : '0;
        fif.inst_valid = inst_valid_c;
        fif.inst       = inst_valid_c ? fq_head.inst : '0;
        fif.inst_pc    = inst_valid_c ? fq_head.pc : '0;
        fif.halted     = (state_q == IF_HALT);
    end

`ifdef IF_FETCH_STAT_EN
    logic [STAT_W-1:0] fetch_cnt_q;

    // Saturating count of pushes; only reset clears it, redirects do not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
        end else if (push) begin
            fetch_cnt_q <= sat_inc(fetch_cnt_q);
        end
    end

    assign fif.fetch_cnt = fetch_cnt_q;
`endif

endmodule
